shared_mem_arbiter: RTL and testbench
=====================================

// Module: shared_mem_arbiter
// PURPOSE
//  Round-robin arbiter sharing one single-port 512x16 data RAM between four cores.
//  Sits between the four core memory interfaces and the RAM, in place of multiporting.
//  Serialises accesses so the RAM never sees more than one access per cycle.
//  Returns read data to the owning core one cycle after its grant.
// PARAMETERS
//  ADDR_W  9   RAM address width (512 words)
//  DATA_W  16  RAM data width
//  (N_PORTS is fixed at 4; one port set per core, suffixes 1..4)
// PORTS
//  clk           in   1       single clock; all state updates on posedge
//  reset_n       in   1       synchronous, active-low reset
//  req1..req4    in   1       core k requests an access; held high until granted
//  we1..we4      in   1       1 = write, 0 = read; stable while reqk=1
//  addr1..addr4  in   ADDR_W  access address; stable while reqk=1
//  wdata1..4     in   DATA_W  write data; stable while reqk=1
//  gnt1..gnt4    out  1       combinational grant; the access completes at the next posedge
//  rvalid1..4    out  1       read data on rdatak is fresh this cycle
//  rdata1..4     out  DATA_W  last read data for core k
//  ram_write_en  out  1       to RAM write enable
//  ram_read_en   out  1       to RAM read enable (registers the RAM read address)
//  ram_addr      out  ADDR_W  to RAM address
//  ram_data_in   out  DATA_W  to RAM write data
//  ram_data_out  in   DATA_W  from RAM; valid the cycle after ram_read_en
// BEHAVIOUR
//  - Arbitration: registered pointer ptr[1:0] names the highest-priority core.
//    Winner = first k with reqk=1, scanning ptr, ptr+1, ... (mod 4).
//    At most one gntk=1 per cycle. No req -> no gnt, ram_*_en=0.
//  - On a grant to core w: ptr <= w+1 (mod 4) at the posedge. Pointer holds when idle.
//    Worst-case wait for a held request is 3 cycles (no starvation).
//  - RAM drive (combinational from winner): ram_addr=addrw; ram_data_in=wdataw;
//    ram_write_en=gnt&wew; ram_read_en=gnt&~wew. When idle, ram_addr=0 and ram_data_in=0.
//  - Read latency 1: grant in cycle N -> rvalidw=1 in cycle N+1. In that cycle,
//    rdataw = ram_data_out. A registered rd_owner/rd_pend pair routes the data.
//  - Per-core hold register: captures ram_data_out at the end of the rvalid cycle.
//    Otherwise rdatak = holdk, so data stays stable until core k's next read.
//  - Writes produce no rvalid. A write granted in N is visible to a read granted in N+1 or later.
//  - A core may re-request in the cycle after its grant. Back-to-back reads by different
//    cores give one rvalid per cycle, with owners in grant order.
//  - Reset (reset_n=0 at posedge), including mid-operation:
//    ptr=0, rd_pend=0, all rvalid=0, all hold=0 (so rdatak=0).
//    gnt and ram_*_en stay combinational and are ignored by cores while reset_n=0.
//    A read granted in the reset cycle is dropped (no rvalid).
//  - Requester contract: reqk must not drop while gntk=0. The arbiter does not check this.
// STRUCTURE
//  - Package mem_arb_pkg: ADDR_W, DATA_W, N_PORTS=4, and the typedef for the 2-bit port index.
//  - Sub-module rr_arbiter4: req[3:0] in, ptr register, one-hot gnt[3:0] and winner index out.
//  - Top level holds the RAM mux, rd_pend/rd_owner and the four hold registers.
// TESTING
//  1 Reset, then req2 read addr 0x005 (RAM preloaded 0x1234) ->
//    gnt2 in cycle 0; rvalid2=1 and rdata2=0x1234 in cycle 1; rdata2 holds 0x1234 after.
//  2 req1..4 all asserted and held from cycle 0, ptr=0 ->
//    gnt order 1,2,3,4 in cycles 0-3; exactly one ram_*_en per cycle.
//  3 req1 write 0x0AA=0xBEEF, then req3 read 0x0AA in the next cycle ->
//    rvalid3=1 with rdata3=0xBEEF.
//  4 req1 held continuously, req4 raised in cycle 2 ->
//    gnt4 within 3 cycles; afterwards grants alternate between 1 and 4.
//  5 Read granted to core 2, reset_n=0 in the next cycle ->
//    rvalid2=0, rdata2=0, ptr=0; the first grant after reset goes to the lowest requesting core.
//  6 No requests for 10 cycles -> ram_write_en=ram_read_en=0, rvalid all 0, ptr unchanged.

Source files
------------

// File: rtl/shared_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_arb_pkg
// Purpose : Shared constants and types for the four-core shared-RAM arbiter.
//           ADDR_W / DATA_W size the 512x16 single-port RAM. N_PORTS is the
//           number of cores. port_idx_t names one core (0..3 = core 1..4).
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    localparam int ADDR_W  = 9;
    localparam int DATA_W  = 16;
    localparam int N_PORTS = 4;

    typedef logic [1:0] port_idx_t;

endpackage
`default_nettype wire

// File: rtl/shared_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : shared_mem_arbiter_if
// Purpose : Bundles the four core request/response channels and the RAM-side
//           signals of the shared memory arbiter.
// Ports   : reqK/weK/addrK/wdataK   core K request (K = 1..4)
//           gntK/rvalidK/rdataK     core K grant and read return
//           ram_write_en/ram_read_en/ram_addr/ram_data_in  to the RAM
//           ram_data_out                                   from the RAM
//           modport slave  : arbiter view
//           modport master : cores + RAM view
// Revision: 1.0 - initial release
// ============================================================================
interface shared_mem_arbiter_if;
    import mem_arb_pkg::*;

    logic              req1, req2, req3, req4;
    logic              we1, we2, we3, we4;
    logic [ADDR_W-1:0] addr1, addr2, addr3, addr4;
    logic [DATA_W-1:0] wdata1, wdata2, wdata3, wdata4;
    logic              gnt1, gnt2, gnt3, gnt4;
    logic              rvalid1, rvalid2, rvalid3, rvalid4;
    logic [DATA_W-1:0] rdata1, rdata2, rdata3, rdata4;
    logic              ram_write_en;
    logic              ram_read_en;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_data_in;
    logic [DATA_W-1:0] ram_data_out;

    modport slave (
        input  req1, req2, req3, req4,
        input  we1, we2, we3, we4,
        input  addr1, addr2, addr3, addr4,
        input  wdata1, wdata2, wdata3, wdata4,
        output gnt1, gnt2, gnt3, gnt4,
        output rvalid1, rvalid2, rvalid3, rvalid4,
        output rdata1, rdata2, rdata3, rdata4,
        output ram_write_en, ram_read_en, ram_addr, ram_data_in,
        input  ram_data_out
    );

    modport master (
        output req1, req2, req3, req4,
        output we1, we2, we3, we4,
        output addr1, addr2, addr3, addr4,
        output wdata1, wdata2, wdata3, wdata4,
        input  gnt1, gnt2, gnt3, gnt4,
        input  rvalid1, rvalid2, rvalid3, rvalid4,
        input  rdata1, rdata2, rdata3, rdata4,
        input  ram_write_en, ram_read_en, ram_addr, ram_data_in,
        output ram_data_out
    );

endinterface
`default_nettype wire

// File: rtl/shared_mem_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter4
// Purpose : Four-way round-robin arbiter. A registered pointer names the
//           highest-priority requester; the winner is the first requester
//           found scanning ptr, ptr+1, ... (mod 4). After a grant the pointer
//           moves just past the winner, so a held request waits at most 3
//           cycles. The pointer holds while idle.
// Ports   : clk         clock
//           reset_n     synchronous active-low reset (ptr <= 0)
//           req[3:0]    requests, bit k = core k+1
//           gnt[3:0]    one-hot combinational grant
//           winner      index of the granted core (valid when grant_valid)
//           grant_valid some request is granted this cycle
// Revision: 1.0 - initial release
// ============================================================================
module rr_arbiter4
    import mem_arb_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic [N_PORTS-1:0] req,
    output logic [N_PORTS-1:0] gnt,
    output port_idx_t          winner,
    output logic               grant_valid
);

    port_idx_t ptr;
    port_idx_t cand;

    // The 2-bit add wraps naturally, giving the modulo-4 scan order.
    always_comb begin
        grant_valid = 1'b0;
        winner      = ptr;
        cand        = ptr;
        gnt         = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            cand = ptr + port_idx_t'(i);
            if (!grant_valid && req[cand]) begin
                grant_valid = 1'b1;
                winner      = cand;
            end
        end
        if (grant_valid) begin
            gnt[winner] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (grant_valid) begin
            ptr <= winner + 2'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/shared_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : shared_mem_arbiter
// Purpose : Shares one single-port 512x16 RAM between four cores using a
//           round-robin arbiter. The winner's address/data/enable are muxed
//           onto the RAM each cycle; read data returns to the owning core one
//           cycle after its grant and is then held per core until its next
//           read completes.
// Ports   : clk      clock, all state on posedge
//           reset_n  synchronous active-low reset
//           bus      shared_mem_arbiter_if.slave (core channels + RAM side)
// Revision: 1.0 - initial release
// ============================================================================
module shared_mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    shared_mem_arbiter_if.slave  bus
);

    logic [N_PORTS-1:0] req_vec;
    logic [N_PORTS-1:0] gnt_vec;
    port_idx_t          winner;
    logic               grant_valid;

    logic               sel_we;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;
    logic               read_en;

    logic               rd_pend;
    port_idx_t          rd_owner;
    logic [N_PORTS-1:0] rvalid_vec;
    logic [DATA_W-1:0]  rdata_arr [N_PORTS];

    assign req_vec = {bus.req4, bus.req3, bus.req2, bus.req1};

    rr_arbiter4 u_arb (
        .clk         (clk),
        .reset_n     (reset_n),
        .req         (req_vec),
        .gnt         (gnt_vec),
        .winner      (winner),
        .grant_valid (grant_valid)
    );

    assign bus.gnt1 = gnt_vec[0];
    assign bus.gnt2 = gnt_vec[1];
    assign bus.gnt3 = gnt_vec[2];
    assign bus.gnt4 = gnt_vec[3];

    // Winner's request fields; only meaningful while grant_valid is high.
    always_comb begin
        sel_we    = bus.we1;
        sel_addr  = bus.addr1;
        sel_wdata = bus.wdata1;
        case (winner)
            2'd1: begin
                sel_we    = bus.we2;
                sel_addr  = bus.addr2;
                sel_wdata = bus.wdata2;
            end
            2'd2: begin
                sel_we    = bus.we3;
                sel_addr  = bus.addr3;
                sel_wdata = bus.wdata3;
            end
            2'd3: begin
                sel_we    = bus.we4;
                sel_addr  = bus.addr4;
                sel_wdata = bus.wdata4;
            end
            default: begin
                sel_we    = bus.we1;
                sel_addr  = bus.addr1;
                sel_wdata = bus.wdata1;
            end
        endcase
    end

    // Idle cycles drive zeros so the RAM bus is quiet and deterministic.
    assign read_en          = grant_valid & ~sel_we;
    assign bus.ram_read_en  = read_en;
    assign bus.ram_write_en = grant_valid & sel_we;
    assign bus.ram_addr     = grant_valid ? sel_addr  : '0;
    assign bus.ram_data_in  = grant_valid ? sel_wdata : '0;

    // Remember who issued the read so the data can be routed next cycle.
    // Reset wins over a read granted in the same cycle, dropping it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_pend  <= 1'b0;
            rd_owner <= '0;
        end else begin
            rd_pend <= read_en;
            if (read_en) begin
                rd_owner <= winner;
            end
        end
    end

    // rvalid is suppressed while reset is asserted so no core sees a return
    // from a read that reset is discarding.
    always_comb begin
        rvalid_vec = '0;
        if (reset_n && rd_pend) begin
            rvalid_vec[rd_owner] = 1'b1;
        end
    end

    for (genvar k = 0; k < N_PORTS; k++) begin : g_hold
        logic [DATA_W-1:0] hold_q;

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                hold_q <= '0;
            end else if (rvalid_vec[k]) begin
                hold_q <= bus.ram_data_out;
            end
        end

        // Fresh RAM data bypasses the hold register in the rvalid cycle.
        assign rdata_arr[k] = rvalid_vec[k] ? bus.ram_data_out : hold_q;
    end

    assign bus.rvalid1 = rvalid_vec[0];
    assign bus.rvalid2 = rvalid_vec[1];
    assign bus.rvalid3 = rvalid_vec[2];
    assign bus.rvalid4 = rvalid_vec[3];

    assign bus.rdata1 = rdata_arr[0];
    assign bus.rdata2 = rdata_arr[1];
    assign bus.rdata3 = rdata_arr[2];
    assign bus.rdata4 = rdata_arr[3];

endmodule
`default_nettype wire

// File: tb/tb_shared_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_shared_mem_arbiter
// Purpose : Directed self-checking bench for shared_mem_arbiter with a
//           behavioural 512x16 RAM and a read-return scoreboard.
// Ports   : none (top-level bench)
// Revision: 1.0 - initial release
// ============================================================================
module tb_shared_mem_arbiter;
    import mem_arb_pkg::*;

    typedef struct packed {
        logic [1:0]  core;
        logic [15:0] data;
    } exp_t;

    logic clk;
    logic reset_n;

    logic [3:0]        req_v;
    logic [3:0]        we_v;
    logic [ADDR_W-1:0] addr_v  [4];
    logic [DATA_W-1:0] wdata_v [4];
    logic [3:0]        gnt_v;
    logic [3:0]        rvalid_v;
    logic [DATA_W-1:0] rdata_v [4];
    logic [DATA_W-1:0] mem [512];

    exp_t sb[$];
    exp_t mon_e;
    int   vectors;
    int   miscompares;

    shared_mem_arbiter_if bus ();

    shared_mem_arbiter dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    assign bus.req1 = req_v[0];
    assign bus.req2 = req_v[1];
    assign bus.req3 = req_v[2];
    assign bus.req4 = req_v[3];
    assign bus.we1  = we_v[0];
    assign bus.we2  = we_v[1];
    assign bus.we3  = we_v[2];
    assign bus.we4  = we_v[3];
    assign bus.addr1 = addr_v[0];
    assign bus.addr2 = addr_v[1];
    assign bus.addr3 = addr_v[2];
    assign bus.addr4 = addr_v[3];
    assign bus.wdata1 = wdata_v[0];
    assign bus.wdata2 = wdata_v[1];
    assign bus.wdata3 = wdata_v[2];
    assign bus.wdata4 = wdata_v[3];

    assign gnt_v    = {bus.gnt4, bus.gnt3, bus.gnt2, bus.gnt1};
    assign rvalid_v = {bus.rvalid4, bus.rvalid3, bus.rvalid2, bus.rvalid1};
    assign rdata_v[0] = bus.rdata1;
    assign rdata_v[1] = bus.rdata2;
    assign rdata_v[2] = bus.rdata3;
    assign rdata_v[3] = bus.rdata4;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port RAM: registered read, write visible next cycle.
    always @(posedge clk) begin
        if (bus.ram_write_en) mem[bus.ram_addr] <= bus.ram_data_in;
        if (bus.ram_read_en)  bus.ram_data_out  <= mem[bus.ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every rvalid must match the oldest outstanding read.
    always @(negedge clk) begin
        if (rvalid_v != 4'b0000) begin
            if (sb.size() == 0) begin
                vectors++;
                assert (rvalid_v === 4'b0000) else begin
                    miscompares++;
                    $error("FAIL sb_unexpected: observed rvalid %b, expected none", rvalid_v);
                end
            end else begin
                mon_e = sb.pop_front();
                check("sb_owner", 32'(rvalid_v), 32'(4'b0001 << mon_e.core));
                check("sb_data", 32'(rdata_v[mon_e.core]), 32'(mon_e.data));
            end
        end
    end

    initial begin
        logic [3:0] t4_tbl [6];
        t4_tbl[0] = 4'b0001; t4_tbl[1] = 4'b0001; t4_tbl[2] = 4'b1000;
        t4_tbl[3] = 4'b0001; t4_tbl[4] = 4'b1000; t4_tbl[5] = 4'b0001;

        vectors = 0;
        miscompares = 0;
        reset_n = 1'b0;
        req_v = '0;
        we_v  = '0;
        for (int i = 0; i < 4; i++) begin
            addr_v[i]  = '0;
            wdata_v[i] = '0;
        end
        for (int i = 0; i < 512; i++) mem[i] = 16'h0000;
        mem[9'h005] = 16'h1234;
        mem[9'h006] = 16'h5678;
        for (int i = 0; i < 4; i++) mem[9'h010 + i] = 16'hC000 + 16'(i);

        // ---- reset state ----
        cyc(); cyc();
        check("rst_ptr", 32'(dut.u_arb.ptr), 32'd0);
        check("rst_rvalid", 32'(rvalid_v), 32'd0);
        for (int i = 0; i < 4; i++) check("rst_rdata", 32'(rdata_v[i]), 32'd0);
        check("rst_idle_en", 32'({bus.ram_write_en, bus.ram_read_en, gnt_v}), 32'd0);
        cyc();

        // ---- 1: single read by core 2 ----
        reset_n = 1'b1;
        req_v[1] = 1'b1; we_v[1] = 1'b0; addr_v[1] = 9'h005;
        #1;
        check("t1_gnt", 32'(gnt_v), 32'b0010);
        check("t1_en", 32'({bus.ram_write_en, bus.ram_read_en}), 32'b01);
        check("t1_addr", 32'(bus.ram_addr), 32'h005);
        sb.push_back('{2'd1, 16'h1234});
        cyc();
        req_v[1] = 1'b0;
        #1;
        check("t1_rvalid", 32'(rvalid_v), 32'b0010);
        check("t1_rdata", 32'(rdata_v[1]), 32'h1234);
        cyc();
        check("t1_rvalid_off", 32'(rvalid_v), 32'd0);
        check("t1_hold", 32'(rdata_v[1]), 32'h1234);

        // ---- 2: all four request, ptr=0 after reset ----
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        check("t2_hold_rst", 32'(rdata_v[1]), 32'd0);
        for (int i = 0; i < 4; i++) begin
            req_v[i] = 1'b1; we_v[i] = 1'b0; addr_v[i] = 9'h010 + 9'(i);
        end
        #1;
        for (int i = 0; i < 4; i++) begin
            check("t2_gnt", 32'(gnt_v), 32'(4'b0001 << i));
            check("t2_one_en", 32'({bus.ram_write_en, bus.ram_read_en}), 32'b01);
            check("t2_addr", 32'(bus.ram_addr), 32'h010 + 32'(i));
            sb.push_back('{2'(i), 16'hC000 + 16'(i)});
            cyc();
            req_v[i] = 1'b0;
            #1;
        end
        cyc();

        // ---- 3: write then read-after-write by another core ----
        req_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 9'h0AA; wdata_v[0] = 16'hBEEF;
        #1;
        check("t3_wgnt", 32'(gnt_v), 32'b0001);
        check("t3_wen", 32'({bus.ram_write_en, bus.ram_read_en}), 32'b10);
        check("t3_wdata", 32'(bus.ram_data_in), 32'hBEEF);
        check("t3_waddr", 32'(bus.ram_addr), 32'h0AA);
        cyc();
        req_v[0] = 1'b0; we_v[0] = 1'b0;
        req_v[2] = 1'b1; we_v[2] = 1'b0; addr_v[2] = 9'h0AA;
        #1;
        check("t3_rgnt", 32'(gnt_v), 32'b0100);
        sb.push_back('{2'd2, 16'hBEEF});
        cyc();
        req_v[2] = 1'b0;
        #1;
        check("t3_rvalid", 32'(rvalid_v), 32'b0100);
        check("t3_rdata", 32'(rdata_v[2]), 32'hBEEF);
        cyc();

        // ---- 4: core 1 held, core 4 joins in cycle 2 (ptr is 3 here) ----
        req_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 9'h100; wdata_v[0] = 16'h1111;
        we_v[3] = 1'b1; addr_v[3] = 9'h101; wdata_v[3] = 16'h4444;
        for (int c = 0; c < 6; c++) begin
            if (c == 2) req_v[3] = 1'b1;
            #1;
            check("t4_gnt", 32'(gnt_v), 32'(t4_tbl[c]));
            cyc();
        end
        req_v[0] = 1'b0; req_v[3] = 1'b0;
        we_v[0] = 1'b0; we_v[3] = 1'b0;
        cyc();
        check("t4_mem1", 32'(mem[9'h100]), 32'h1111);
        check("t4_mem4", 32'(mem[9'h101]), 32'h4444);

        // ---- 5: reset the cycle after a read grant (ptr is 1 here) ----
        req_v[1] = 1'b1; addr_v[1] = 9'h005;
        #1;
        check("t5_gnt_a", 32'(gnt_v), 32'b0010);
        sb.push_back('{2'd1, 16'h1234});
        cyc();
        addr_v[1] = 9'h006;
        #1;
        check("t5_gnt_b", 32'(gnt_v), 32'b0010);
        check("t5_rdata_a", 32'(rdata_v[1]), 32'h1234);
        cyc();
        req_v[1] = 1'b0;
        reset_n = 1'b0;
        req_v[0] = 1'b1; addr_v[0] = 9'h010;
        req_v[3] = 1'b1; addr_v[3] = 9'h013;
        #1;
        check("t5_rvalid_rst", 32'(rvalid_v), 32'd0);
        cyc();
        reset_n = 1'b1;
        #1;
        check("t5_rvalid_after", 32'(rvalid_v), 32'd0);
        check("t5_rdata2_clr", 32'(rdata_v[1]), 32'd0);
        check("t5_ptr", 32'(dut.u_arb.ptr), 32'd0);
        check("t5_first_gnt", 32'(gnt_v), 32'b0001);
        sb.push_back('{2'd0, 16'hC000});
        cyc();
        req_v[0] = 1'b0;
        #1;
        check("t5_second_gnt", 32'(gnt_v), 32'b1000);
        sb.push_back('{2'd3, 16'hC003});
        cyc();
        req_v[3] = 1'b0;
        #1;
        check("t5_rdata4", 32'(rdata_v[3]), 32'hC003);
        cyc();

        // ---- 6: ten idle cycles ----
        for (int c = 0; c < 10; c++) begin
            #1;
            check("t6_idle", 32'({bus.ram_write_en, bus.ram_read_en, gnt_v, rvalid_v}), 32'd0);
            check("t6_bus", 32'({bus.ram_addr, bus.ram_data_in}), 32'd0);
            cyc();
        end
        check("t6_ptr", 32'(dut.u_arb.ptr), 32'd0);
        check("t6_hold4", 32'(rdata_v[3]), 32'hC003);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
